// File: rtl/fpu_arbiter.sv
// Round-robin arbiter and sequencer sharing one FPU between two requesters.
// Optional watchdog abort is built when FPU_ARB_TIMEOUT_EN is defined.
module fpu_arbiter #(
  parameter int FPU_W   = 32,
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             r0_req_i,
  input  logic             r1_req_i,
  input  logic [OP_W-1:0]  r0_op_i,
  input  logic [OP_W-1:0]  r1_op_i,
  input  logic [FPU_W-1:0] r0_a_i,
  input  logic [FPU_W-1:0] r0_b_i,
  input  logic [FPU_W-1:0] r1_a_i,
  input  logic [FPU_W-1:0] r1_b_i,
  output logic             r0_gnt_o,
  output logic             r1_gnt_o,
  output logic             r0_done_o,
  output logic             r1_done_o,
  output logic [FPU_W-1:0] res_o,
  output logic [4:0]       flags_o,
  output logic             fpu_start_o,
  output logic [OP_W-1:0]  fpu_op_o,
  output logic [FPU_W-1:0] fpu_a_o,
  output logic [FPU_W-1:0] fpu_b_o,
  input  logic             fpu_done_i,
  input  logic [FPU_W-1:0] fpu_res_i,
  input  logic [4:0]       fpu_flags_i,
  output logic             busy_o,
  output logic             owner_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic             owner, last_owner, win, wd_expire;
  logic [OP_W-1:0]  op_q;
  logic [FPU_W-1:0] a_q, b_q, res_q;
  logic [4:0]       flags_q;

  // On a tie the requester that did not own the FPU last time wins.
  assign win = (r0_req_i && r1_req_i) ? ~last_owner : r1_req_i;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wd_cnt;
  logic          timed_out;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wd_cnt    <= '0;
      timed_out <= 1'b0;
    end else if (state == ISSUE) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      if (fpu_done_i) begin
        timed_out <= 1'b0;
      end else begin
        wd_cnt <= wd_cnt + CW'(1);
        if (wd_cnt == WD_LAST) timed_out <= 1'b1;
      end
    end
  end

  assign wd_expire = (state == WAIT) && !fpu_done_i && (wd_cnt == WD_LAST);
  assign timeout_o = (state == RESP) && timed_out;
`else
  assign wd_expire = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (r0_req_i || r1_req_i) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (fpu_done_i || wd_expire) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are latched on the win so later input changes cannot reach the FPU.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      flags_q    <= '0;
    end else begin
      case (state)
        IDLE: if (r0_req_i || r1_req_i) begin
          owner <= win;
          op_q  <= win ? r1_op_i : r0_op_i;
          a_q   <= win ? r1_a_i  : r0_a_i;
          b_q   <= win ? r1_b_i  : r0_b_i;
        end
        WAIT: if (fpu_done_i) begin
          res_q   <= fpu_res_i;
          flags_q <= fpu_flags_i;
        end else if (wd_expire) begin
          res_q   <= FPU_W'(32'h7FC00000);
          flags_q <= 5'b10000;
        end
        RESP:    last_owner <= owner;
        default: ;
      endcase
    end
  end

  assign busy_o      = (state != IDLE);
  assign fpu_start_o = (state == ISSUE);
  assign r0_gnt_o    = (state == ISSUE) && !owner;
  assign r1_gnt_o    = (state == ISSUE) &&  owner;
  assign r0_done_o   = (state == RESP)  && !owner;
  assign r1_done_o   = (state == RESP)  &&  owner;
  assign owner_o     = owner;
  assign fpu_op_o    = op_q;
  assign fpu_a_o     = a_q;
  assign fpu_b_o     = b_q;
  assign res_o       = res_q;
  assign flags_o     = flags_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Randomized bench for fpu_arbiter, checked against a transaction-level model
// that tracks grant/response cycle stamps per operation.
module tb_fpu_arbiter;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r1_req;
  logic [2:0]  r0_op, r1_op;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic        r0_gnt, r1_gnt, r0_done, r1_done;
  logic [31:0] res;
  logic [4:0]  flags;
  logic        fpu_start;
  logic [2:0]  fpu_op;
  logic [31:0] fpu_a, fpu_b;
  logic        fpu_done;
  logic [31:0] fpu_res;
  logic [4:0]  fpu_flags;
  logic        busy, owner, timeout;

  fpu_arbiter #(.FPU_W(32), .OP_W(3), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .r0_req_i(r0_req), .r1_req_i(r1_req),
    .r0_op_i(r0_op), .r1_op_i(r1_op),
    .r0_a_i(r0_a), .r0_b_i(r0_b), .r1_a_i(r1_a), .r1_b_i(r1_b),
    .r0_gnt_o(r0_gnt), .r1_gnt_o(r1_gnt),
    .r0_done_o(r0_done), .r1_done_o(r1_done),
    .res_o(res), .flags_o(flags),
    .fpu_start_o(fpu_start), .fpu_op_o(fpu_op),
    .fpu_a_o(fpu_a), .fpu_b_o(fpu_b),
    .fpu_done_i(fpu_done), .fpu_res_i(fpu_res), .fpu_flags_i(fpu_flags),
    .busy_o(busy), .owner_o(owner), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int resets = 0;

  // Reference model: one in-flight operation described by its cycle stamps.
  bit          m_active, m_owner, m_last, m_to;
  int          m_issue, m_resp, fpu_due;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_res;
  logic [4:0]  m_flags;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic modelReset();
    m_active = 1'b0;
    m_owner  = 1'b0;
    m_last   = 1'b1;
    m_to     = 1'b0;
    m_issue  = -10;
    m_resp   = -10;
    m_res    = '0;
    m_flags  = '0;
    fpu_due  = -1;
  endtask

  task automatic checkIdleReset();
    checkOutput("rst_busy",  32'(busy), 32'd0);
    checkOutput("rst_gnt",   32'({r0_gnt, r1_gnt, fpu_start}), 32'd0);
    checkOutput("rst_done",  32'({r0_done, r1_done, timeout}), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);
    checkOutput("rst_res",   res, 32'd0);
    checkOutput("rst_flags", 32'(flags), 32'd0);
  endtask

  task automatic checkCycle();
    bit g, d;
    g = m_active && (cyc == m_issue);
    d = m_active && (cyc == m_resp);
    checkOutput("gnt0",    32'(r0_gnt),    32'(g && !m_owner));
    checkOutput("gnt1",    32'(r1_gnt),    32'(g &&  m_owner));
    checkOutput("start",   32'(fpu_start), 32'(g));
    checkOutput("done0",   32'(r0_done),   32'(d && !m_owner));
    checkOutput("done1",   32'(r1_done),   32'(d &&  m_owner));
    checkOutput("busy",    32'(busy),      32'(m_active));
    checkOutput("owner",   32'(owner),     32'(m_owner));
    checkOutput("timeout", 32'(timeout),   32'(d && m_to));
    if (d) begin
      checkOutput("res",   res,         m_res);
      checkOutput("flags", 32'(flags),  32'(m_flags));
    end
    if (m_active) begin
      checkOutput("fpu_op", 32'(fpu_op), 32'(m_op));
      checkOutput("fpu_a",  fpu_a, m_a);
      checkOutput("fpu_b",  fpu_b, m_b);
    end
  endtask

  // Drives requesters and FPU for the coming edge, then advances the model.
  task automatic applyStimulus();
    bit w;
    if (m_active && cyc == m_resp) begin
      if (m_owner) r1_req = 1'b0; else r0_req = 1'b0;
    end else begin
      if (!r0_req && $urandom_range(3) == 0) begin
        r0_req = 1'b1; r0_op = 3'($urandom); r0_a = $urandom; r0_b = $urandom;
      end
      if (!r1_req && $urandom_range(3) == 0) begin
        r1_req = 1'b1; r1_op = 3'($urandom); r1_a = $urandom; r1_b = $urandom;
      end
    end
    if (m_active && cyc >= m_issue) begin
      if (m_owner) begin r1_op = 3'($urandom); r1_a = $urandom; r1_b = $urandom; end
      else         begin r0_op = 3'($urandom); r0_a = $urandom; r0_b = $urandom; end
    end

    if (m_active && cyc == m_issue) begin
      fpu_due = cyc + 1 + int'($urandom_range(4));
`ifdef FPU_ARB_TIMEOUT_EN
      if ($urandom_range(3) == 0) fpu_due = -1;
`endif
    end
    fpu_res   = $urandom;
    fpu_flags = 5'($urandom);
    fpu_done  = (cyc == fpu_due) || ($urandom_range(7) == 0);

    if (!m_active) begin
      if (r0_req || r1_req) begin
        w        = (r0_req && r1_req) ? !m_last : r1_req;
        m_owner  = w;
        m_op     = w ? r1_op : r0_op;
        m_a      = w ? r1_a  : r0_a;
        m_b      = w ? r1_b  : r0_b;
        m_active = 1'b1;
        m_issue  = cyc + 1;
        m_resp   = -1;
        m_to     = 1'b0;
      end
    end else if (cyc == m_resp) begin
      m_active = 1'b0;
      m_last   = m_owner;
      fpu_due  = -1;
    end else if (cyc > m_issue && m_resp < 0) begin
      if (fpu_done) begin
        m_resp  = cyc + 1;
        m_res   = fpu_res;
        m_flags = fpu_flags;
      end
`ifdef FPU_ARB_TIMEOUT_EN
      else if (cyc - m_issue == TO) begin
        m_resp  = cyc + 1;
        m_res   = 32'h7FC00000;
        m_flags = 5'b10000;
        m_to    = 1'b1;
      end
`endif
    end
    cyc++;
  endtask

  task automatic forceTie();
    r0_req = 1'b1; r0_op = 3'($urandom); r0_a = $urandom; r0_b = $urandom;
    r1_req = 1'b1; r1_op = 3'($urandom); r1_a = $urandom; r1_b = $urandom;
  endtask

  // Reset pulled mid-operation: outputs must clear without waiting for a clock.
  task automatic midOpReset();
    rst_n = 1'b0;
    #1;
    checkIdleReset();
    modelReset();
    r0_req = 1'b0;
    r1_req = 1'b0;
    resets++;
    #1 rst_n = 1'b1;
    forceTie();
  endtask

  initial begin
    rst_n = 1'b0;
    r0_req = 1'b0; r1_req = 1'b0;
    r0_op = '0; r1_op = '0;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    fpu_done = 1'b0; fpu_res = '0; fpu_flags = '0;
    modelReset();

    repeat (2) @(negedge clk);
    checkIdleReset();
    rst_n = 1'b1;
    forceTie();
    applyStimulus();

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checkCycle();
      if (m_active && cyc > m_issue && m_resp < 0 && resets < 4 && $urandom_range(49) == 0)
        midOpReset();
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
